// File: rtl/mem_stage_pkg.sv
// Shared command codes, FSM encoding and command decode helpers for the memory stage.
// Byte-serial access with an 8-bit RAM bus; state encoding is 2 bits.
package mem_stage_pkg;

  localparam int CMD_TYPE_W = 6;
  localparam int MEM_BYTE_W = 8;

  localparam logic [CMD_TYPE_W-1:0] CMD_NOP  = 6'd0;
  localparam logic [CMD_TYPE_W-1:0] CMD_ADDI = 6'd1;
  localparam logic [CMD_TYPE_W-1:0] CMD_LB   = 6'd10;
  localparam logic [CMD_TYPE_W-1:0] CMD_LH   = 6'd11;
  localparam logic [CMD_TYPE_W-1:0] CMD_LW   = 6'd12;
  localparam logic [CMD_TYPE_W-1:0] CMD_LBU  = 6'd13;
  localparam logic [CMD_TYPE_W-1:0] CMD_LHU  = 6'd14;
  localparam logic [CMD_TYPE_W-1:0] CMD_SB   = 6'd15;
  localparam logic [CMD_TYPE_W-1:0] CMD_SH   = 6'd16;
  localparam logic [CMD_TYPE_W-1:0] CMD_SW   = 6'd17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  function automatic logic is_load(input logic [CMD_TYPE_W-1:0] cmd);
    return (cmd == CMD_LB) || (cmd == CMD_LH) || (cmd == CMD_LW) ||
           (cmd == CMD_LBU) || (cmd == CMD_LHU);
  endfunction

  function automatic logic is_store(input logic [CMD_TYPE_W-1:0] cmd);
    return (cmd == CMD_SB) || (cmd == CMD_SH) || (cmd == CMD_SW);
  endfunction

  // Index of the final byte of the access (N-1).
  function automatic logic [1:0] last_byte(input logic [CMD_TYPE_W-1:0] cmd);
    case (cmd)
      CMD_LH, CMD_LHU, CMD_SH: return 2'd1;
      CMD_LW, CMD_SW:          return 2'd3;
      default:                 return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_extend.sv
// Load result extension: sign/zero-extends the assembled byte buffer by load type.
// Purely combinational; reusable by a future load cache.
module load_extend
  import mem_stage_pkg::*;
(
  input  logic [CMD_TYPE_W-1:0] cmdtype,
  input  logic [31:0]           buffer,
  output logic [31:0]           result
);

  always_comb begin
    result = buffer;
    case (cmdtype)
      CMD_LB:  result = {{24{buffer[7]}}, buffer[7:0]};
      CMD_LBU: result = {24'd0, buffer[7:0]};
      CMD_LH:  result = {{16{buffer[15]}}, buffer[15:0]};
      CMD_LHU: result = {16'd0, buffer[15:0]};
      default: result = buffer;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through, or runs loads/stores byte-serially on the arbiter port.
// Load DONE at c0+2N+1, store at c0+N+1 with constant grant; stall_req holds upstream until DONE.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int CMD_W  = CMD_TYPE_W,
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [CMD_W-1:0]  cmdtype_in,
  input  logic [4:0]        rsd_addr_in,
  input  logic [31:0]       rsd_data_in,
  input  logic              write_rsd_in,
  input  logic [31:0]       mem_addr_in,
  input  logic [31:0]       store_val_in,
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic              mem_grant_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              stall_req,
  output logic [4:0]        rsd_addr_out,
  output logic [31:0]       rsd_data_out,
  output logic              write_rsd_out,
  output logic              mem_forward_id_o,
  output logic [4:0]        mem_forward_addr_o,
  output logic [31:0]       mem_forward_data_o
);

  mem_state_e  state, state_nxt;
  logic [1:0]  k, k_nxt;
  logic [31:0] buffer;
  logic        capture;
  logic        ld, st, is_mem;
  logic [1:0]  k_last;
  logic [31:0] addr_sum;
  logic [31:0] ext_data;
  wb_t         wb;

  assign ld       = is_load(cmdtype_in);
  assign st       = is_store(cmdtype_in);
  assign is_mem   = ld | st;
  assign k_last   = last_byte(cmdtype_in);
  assign addr_sum = mem_addr_in + {30'd0, k};

  load_extend u_load_extend (
    .cmdtype (cmdtype_in),
    .buffer  (buffer),
    .result  (ext_data)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= ST_IDLE;
      k      <= 2'd0;
      buffer <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (capture) begin
        buffer[{k, 3'b000} +: MEM_BYTE_W] <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    capture     = 1'b0;
    mem_req_o   = 1'b0;
    mem_wr_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    stall_req   = 1'b0;
    wb          = '0;
    case (state)
      ST_IDLE: begin
        if (is_mem) begin
          stall_req = 1'b1;
          state_nxt = ST_REQ;
          k_nxt     = 2'd0;
        end else begin
          wb.wr   = write_rsd_in;
          wb.addr = rsd_addr_in;
          wb.data = rsd_data_in;
        end
      end
      ST_REQ: begin
        // Request fields depend only on k and the held ex_mem inputs, so they stay put until granted.
        stall_req   = 1'b1;
        mem_req_o   = 1'b1;
        mem_wr_o    = st;
        mem_addr_o  = ADDR_W'(addr_sum);
        mem_wdata_o = store_val_in[{k, 3'b000} +: MEM_BYTE_W];
        if (mem_grant_i) begin
          if (!st) begin
            state_nxt = ST_WAIT_R;
          end else if (k == k_last) begin
            state_nxt = ST_DONE;
            k_nxt     = 2'd0;
          end else begin
            k_nxt = k + 2'd1;
          end
        end
      end
      ST_WAIT_R: begin
        stall_req = 1'b1;
        capture   = 1'b1;
        if (k == k_last) begin
          state_nxt = ST_DONE;
          k_nxt     = 2'd0;
        end else begin
          state_nxt = ST_REQ;
          k_nxt     = k + 2'd1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        k_nxt     = 2'd0;
        if (ld) begin
          wb.wr   = 1'b1;
          wb.addr = rsd_addr_in;
          wb.data = ext_data;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rst_in) begin
      mem_req_o   = 1'b0;
      mem_wr_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      stall_req   = 1'b0;
      wb          = '0;
    end
  end

  assign rsd_addr_out       = wb.addr;
  assign rsd_data_out       = wb.data;
  assign write_rsd_out      = wb.wr;
  assign mem_forward_id_o   = wb.wr;
  assign mem_forward_addr_o = wb.addr;
  assign mem_forward_data_o = wb.data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset corner cases, and random ops
// checked against a byte-level reference model of accesses and load results.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [5:0]  cmdtype_in;
  logic [4:0]  rsd_addr_in;
  logic [31:0] rsd_data_in;
  logic        write_rsd_in;
  logic [31:0] mem_addr_in;
  logic [31:0] store_val_in;
  logic        mem_req_o;
  logic        mem_wr_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_grant_i;
  logic [7:0]  mem_rdata_i;
  logic        stall_req;
  logic [4:0]  rsd_addr_out;
  logic [31:0] rsd_data_out;
  logic        write_rsd_out;
  logic        mem_forward_id_o;
  logic [4:0]  mem_forward_addr_o;
  logic [31:0] mem_forward_data_o;

  int tests = 0;
  int fails = 0;

  logic [7:0] ram [logic [31:0]];

  mem_stage #(.CMD_W(6), .ADDR_W(32)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .cmdtype_in         (cmdtype_in),
    .rsd_addr_in        (rsd_addr_in),
    .rsd_data_in        (rsd_data_in),
    .write_rsd_in       (write_rsd_in),
    .mem_addr_in        (mem_addr_in),
    .store_val_in       (store_val_in),
    .mem_req_o          (mem_req_o),
    .mem_wr_o           (mem_wr_o),
    .mem_addr_o         (mem_addr_o),
    .mem_wdata_o        (mem_wdata_o),
    .mem_grant_i        (mem_grant_i),
    .mem_rdata_i        (mem_rdata_i),
    .stall_req          (stall_req),
    .rsd_addr_out       (rsd_addr_out),
    .rsd_data_out       (rsd_data_out),
    .write_rsd_out      (write_rsd_out),
    .mem_forward_id_o   (mem_forward_id_o),
    .mem_forward_addr_o (mem_forward_addr_o),
    .mem_forward_data_o (mem_forward_data_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic int nbytes(input logic [5:0] c);
    if (c == CMD_LB || c == CMD_LBU || c == CMD_SB) return 1;
    if (c == CMD_LH || c == CMD_LHU || c == CMD_SH) return 2;
    if (c == CMD_LW || c == CMD_SW) return 4;
    return 0;
  endfunction

  function automatic logic tb_is_ld(input logic [5:0] c);
    return c == CMD_LB || c == CMD_LH || c == CMD_LW || c == CMD_LBU || c == CMD_LHU;
  endfunction

  function automatic logic tb_is_st(input logic [5:0] c);
    return c == CMD_SB || c == CMD_SH || c == CMD_SW;
  endfunction

  // Little-endian assembly as an integer, then signed reinterpretation for LB/LH.
  function automatic logic [31:0] model_load(input logic [5:0] c, input logic [31:0] addr);
    logic [31:0] raw;
    logic [31:0] a;
    int n;
    n = nbytes(c);
    raw = 32'd0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      raw = raw + (32'(ram_byte(a)) << (8 * i));
    end
    if ((c == CMD_LB || c == CMD_LH) && raw >= (32'd1 << (8 * n - 1)))
      raw = raw - (32'd1 << (8 * n));
    return raw;
  endfunction

  // gmode: 0 = grant always, 1 = random grant, 2 = withhold the first gwait requested cycles.
  task automatic run_op(input logic [5:0] cmd, input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] sval, input logic [31:0] alu, input logic wen,
                        input int gmode, input int gwait, input logic [31:0] exp_data,
                        input int exp_lat, input string tag);
    logic [40:0] exp_q[$];
    logic [40:0] got_q[$];
    logic [40:0] cur, held;
    logic [31:0] a, sh;
    logic        held_vld, done, rd_hit, exp_wr;
    logic [7:0]  rd_next;
    logic        o_wr, o_req, f_vld;
    logic [4:0]  o_addr, f_addr;
    logic [31:0] o_data, f_data;
    int          n, cyc, done_cyc, withheld, hold_bad, wb_bad;
    n = nbytes(cmd);
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      sh = sval >> (8 * i);
      exp_q.push_back({tb_is_st(cmd), a, sh[7:0]});
    end
    exp_wr = tb_is_ld(cmd) ? 1'b1 : (tb_is_st(cmd) ? 1'b0 : wen);
    cmdtype_in = cmd; rsd_addr_in = rd; rsd_data_in = alu; write_rsd_in = wen;
    mem_addr_in = addr; store_val_in = sval;
    held = '0; held_vld = 1'b0; done = 1'b0; rd_hit = 1'b0; rd_next = 8'd0;
    cyc = 0; done_cyc = -1; withheld = 0; hold_bad = 0; wb_bad = 0;
    o_wr = 1'b0; o_req = 1'b0; f_vld = 1'b0; o_addr = '0; f_addr = '0; o_data = '0; f_data = '0;
    while (!done && cyc < 300) begin
      if (gmode == 0) mem_grant_i = 1'b1;
      else if (gmode == 1) mem_grant_i = 1'($urandom_range(0, 1));
      else if (mem_req_o && withheld < gwait) begin
        mem_grant_i = 1'b0;
        withheld++;
      end else mem_grant_i = 1'b1;
      mem_rdata_i = rd_hit ? rd_next : 8'($urandom);
      rd_hit = 1'b0;
      @(negedge clk_in);
      if (!stall_req) begin
        done = 1'b1; done_cyc = cyc;
        o_wr = write_rsd_out; o_addr = rsd_addr_out; o_data = rsd_data_out; o_req = mem_req_o;
        f_vld = mem_forward_id_o; f_addr = mem_forward_addr_o; f_data = mem_forward_data_o;
      end else begin
        if (write_rsd_out || mem_forward_id_o) wb_bad++;
        if (mem_req_o) begin
          cur = {mem_wr_o, mem_addr_o, mem_wdata_o};
          if (held_vld && cur !== held) hold_bad++;
          if (mem_grant_i) begin
            got_q.push_back(cur);
            held_vld = 1'b0;
            if (!mem_wr_o) begin
              rd_hit = 1'b1;
              rd_next = ram_byte(mem_addr_o);
            end
          end else begin
            held = cur; held_vld = 1'b1;
          end
        end else begin
          if (held_vld) hold_bad++;
          held_vld = 1'b0;
        end
      end
      @(posedge clk_in); #1;
      cyc++;
    end
    check({tag, ".done"}, done, 1);
    check({tag, ".n_acc"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s.acc%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, ".hold"}, hold_bad, 0);
    check({tag, ".wb_in_stall"}, wb_bad, 0);
    check({tag, ".done_req"}, o_req, 0);
    check({tag, ".wr"}, o_wr, exp_wr);
    check({tag, ".fwd_vld"}, f_vld, exp_wr);
    if (!tb_is_st(cmd)) begin
      check({tag, ".data"}, o_data, exp_data);
      check({tag, ".rd"}, o_addr, rd);
      check({tag, ".fwd"}, {f_addr, f_data}, {rd, exp_data});
    end
    if (exp_lat >= 0) check({tag, ".lat"}, done_cyc, exp_lat);
  endtask

  typedef struct {
    logic [5:0]  cmd;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] sval;
    logic [31:0] alu;
    logic        wen;
    int          gmode;
    int          gwait;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];
  logic [5:0] cmds[9];

  initial begin
    logic [5:0]  c;
    logic [31:0] ad, ed;
    rst_in = 1'b1; cmdtype_in = CMD_LW; rsd_addr_in = 5'd7; rsd_data_in = 32'hDEADBEEF;
    write_rsd_in = 1'b1; mem_addr_in = 32'h100; store_val_in = 32'h1234; mem_grant_i = 1'b1;
    mem_rdata_i = 8'h00;

    ram[32'h1000] = 8'h78; ram[32'h1001] = 8'h56; ram[32'h1002] = 8'h34; ram[32'h1003] = 8'h12;
    ram[32'h20] = 8'h80; ram[32'h22] = 8'hFF; ram[32'h23] = 8'h7F;
    ram[32'h30] = 8'h01; ram[32'h31] = 8'h80;

    vecs[0]  = '{CMD_ADDI, 5'd5, 32'h0,        32'h0,        32'h12, 1'b1, 0, 0, 32'h12,       0};
    vecs[1]  = '{CMD_LW,   5'd3, 32'h1000,     32'h0,        32'h0,  1'b0, 0, 0, 32'h12345678, 9};
    vecs[2]  = '{CMD_LB,   5'd4, 32'h20,       32'h0,        32'h0,  1'b0, 0, 0, 32'hFFFFFF80, 3};
    vecs[3]  = '{CMD_LBU,  5'd6, 32'h20,       32'h0,        32'h0,  1'b0, 0, 0, 32'h00000080, 3};
    vecs[4]  = '{CMD_LH,   5'd8, 32'h22,       32'h0,        32'h0,  1'b0, 0, 0, 32'h00007FFF, 5};
    vecs[5]  = '{CMD_SH,   5'd9, 32'h40,       32'hAABBCCDD, 32'h0,  1'b0, 2, 3, 32'h0,        6};
    vecs[6]  = '{CMD_SW,   5'd1, 32'hFFFFFFFE, 32'h11223344, 32'h0,  1'b0, 0, 0, 32'h0,        5};
    vecs[7]  = '{CMD_LHU,  5'd2, 32'h30,       32'h0,        32'h0,  1'b0, 0, 0, 32'h00008001, 5};
    vecs[8]  = '{CMD_LH,   5'd2, 32'h30,       32'h0,        32'h0,  1'b0, 0, 0, 32'hFFFF8001, 5};
    vecs[9]  = '{CMD_ADDI, 5'd0, 32'h0,        32'h0,        32'h55, 1'b0, 0, 0, 32'h55,       0};
    vecs[10] = '{CMD_SB,   5'd1, 32'h50,       32'h123456EE, 32'h0,  1'b0, 0, 0, 32'h0,        2};

    cmds = '{CMD_LB, CMD_LH, CMD_LW, CMD_LBU, CMD_LHU, CMD_SB, CMD_SH, CMD_SW, CMD_ADDI};

    // Reset with a load presented: every output must stay low.
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("rst_outs", |{mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o, stall_req, rsd_addr_out,
                        rsd_data_out, write_rsd_out, mem_forward_id_o, mem_forward_addr_o,
                        mem_forward_data_o}, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].cmd, vecs[i].rd, vecs[i].addr, vecs[i].sval, vecs[i].alu, vecs[i].wen,
             vecs[i].gmode, vecs[i].gwait, vecs[i].exp_data, vecs[i].exp_lat,
             $sformatf("vec%0d", i));

    // Reset during the second WAIT_R of an LW (k already advanced), then an ADDI and a clean LW.
    cmdtype_in = CMD_LW; rsd_addr_in = 5'd3; mem_addr_in = 32'h1000; mem_grant_i = 1'b1;
    repeat (4) begin
      @(posedge clk_in); #1;
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    check("rst_wait_r_outs", |{mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o, stall_req,
                               rsd_addr_out, rsd_data_out, write_rsd_out, mem_forward_id_o,
                               mem_forward_addr_o, mem_forward_data_o}, 0);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("rst_next_outs", |{mem_req_o, stall_req, write_rsd_out, rsd_data_out}, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    run_op(CMD_ADDI, 5'd5, 32'h0, 32'h0, 32'h12, 1'b1, 0, 0, 32'h12, 0, "post_rst_addi");
    run_op(CMD_LW, 5'd3, 32'h1000, 32'h0, 32'h0, 1'b0, 0, 0, 32'h12345678, 9, "post_rst_lw");

    for (int r = 0; r < 40; r++) begin
      c = cmds[$urandom_range(0, 8)];
      ad = $urandom;
      if ($urandom_range(0, 3) == 0) ad = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      ed = $urandom;
      if (tb_is_ld(c)) ed = model_load(c, ad);
      run_op(c, 5'($urandom), ad, $urandom, ed, 1'($urandom_range(0, 1)), 1, 0, ed, -1,
             $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage. Sits between the ex_mem pipeline latch (fed by EX) and the mem_wb latch.
- Non-memory commands pass straight through to mem_wb.
- Loads and stores become a byte-serial sequence of requests on the data port of the memory arbiter; the 8-bit RAM bus carries one byte per access.
- Holds the pipeline through stall_req until the access completes, then returns write-back data and a forwarding path to ID.

Parameters:
- CMD_W, 6, width of the command-type bus (matches `Cmd_Typebus).
- ADDR_W, 32, byte-address width on the data port.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous reset, active-high
- cmdtype_in  input  CMD_W  command from ex_mem
- rsd_addr_in  input  5  destination register
- rsd_data_in  input  32  ALU result (non-load)
- write_rsd_in  input  1  write-back enable from EX
- mem_addr_in  input  32  effective address
- store_val_in  input  32  store data
- mem_req_o  output  1  byte request to arbiter
- mem_wr_o  output  1  1 = write, 0 = read
- mem_addr_o  output  ADDR_W  byte address
- mem_wdata_o  output  8  write byte
- mem_grant_i  input  1  arbiter accepts request this cycle
- mem_rdata_i  input  8  read byte, valid the cycle after a read grant
- stall_req  output  1  hold IF/ID/EX and the ex_mem latch
- rsd_addr_out  output  5  to mem_wb
- rsd_data_out  output  32  to mem_wb
- write_rsd_out  output  1  to mem_wb
- mem_forward_id_o  output  1  forward valid to ID
- mem_forward_addr_o  output  5  forward register
- mem_forward_data_o  output  32  forward data

Behaviour:
- Clock and reset: clk_in is the only clock. rst_in is synchronous, active-high. Reset forces state IDLE and k=0, clears the data buffer, and drives mem_req_o=0 and stall_req=0. While in reset, all outputs are 0 regardless of inputs.
- Byte count N: LB/LBU/SB=1, LH/LHU/SH=2, LW/SW=4. Byte k is at address mem_addr_in+k, wrapping modulo 2^ADDR_W. Byte order is little-endian.
- State IDLE:
  - Non-memory command: outputs copy rsd_addr_in, rsd_data_in and write_rsd_in combinationally; stall_req=0.
  - Memory command: stall_req=1 combinationally and write_rsd_out=0; next state REQ with k=0.
- State REQ:
  - mem_req_o=1. mem_addr_o, mem_wr_o and mem_wdata_o (store_val_in[8k+7:8k]) stay stable until mem_grant_i=1.
  - On grant of a read: go to WAIT_R.
  - On grant of a write: k++; if k==N-1 go to DONE, otherwise stay in REQ.
  - No grant: stay in REQ and hold the request.
- State WAIT_R:
  - mem_req_o=0. Capture mem_rdata_i into buffer byte k, then k++.
  - If k==N-1 go to DONE, otherwise go to REQ.
- State DONE:
  - stall_req=0 for exactly one cycle.
  - Loads: write_rsd_out=1, rsd_addr_out=rsd_addr_in, rsd_data_out=load_extend(buffer).
  - Stores: write_rsd_out=0.
  - Next state is IDLE. The ex_mem latch advances on this edge, so the command is never replayed.
- stall_req is 1 in REQ and WAIT_R, and in IDLE whenever the command is a memory command.
- Latency with mem_grant_i always 1, counted from the cycle a memory command first appears in IDLE (c0): load reaches DONE at c0+2N+1; store reaches DONE at c0+N+1.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW uses the buffer as-is.
- Forwarding: mem_forward_id_o=write_rsd_out, with mem_forward_addr_o and mem_forward_data_o mirroring the write-back outputs. A load forwards only in DONE.
- Grant arrives late, or drops while in REQ: no effect beyond waiting; the request is held unchanged.
- Changes on cmdtype_in during REQ/WAIT_R cannot occur, because stall_req holds the ex_mem latch. Behaviour is unspecified if they do.
- Reset during REQ/WAIT_R: next cycle the block is in IDLE with mem_req_o=0, and the partial access is abandoned.
- Write to x0: passed through unchanged; suppression is the register file's job.

Decomposition:
- Command codes (CmdLB…CmdSW) and widths live in the shared define.v. Add macros MemByte_W=8 and the FSM state encodings (2 bits) there.
- Sub-module load_extend: combinational, takes cmdtype and the 32-bit buffer and returns the 32-bit extended result. It is reusable by a future load cache.

Test Plan:
- ADDI x5 result 0x12, write_rsd_in=1 -> same cycle: write_rsd_out=1, rsd_data_out=0x12, stall_req=0, mem_req_o=0.
- LW x3 at 0x1000, grant always 1, RAM bytes 78 56 34 12 -> addresses 0x1000..0x1003 requested with wr=0; DONE at c0+9 with rsd_data_out=0x12345678; stall_req=1 from c0 to c0+8.
- LB and LBU at 0x20 holding 0x80 -> LB gives 0xFFFFFF80, LBU gives 0x00000080; LH at 0x22 holding 0x7FFF gives 0x00007FFF.
- SH store_val_in=0xAABBCCDD at 0x40, grant withheld for 3 cycles on byte 0 -> byte 0 stays 0xDD@0x40 unchanged until granted, then 0xCC@0x41; write_rsd_out=0 throughout; DONE one cycle after the last grant.
- SW at 0xFFFFFFFE -> byte addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- rst_in=1 while in WAIT_R of an LW -> next cycle: IDLE, mem_req_o=0, stall_req=0, all outputs 0; a following ADDI passes through normally.
